seq_scan_ctrl: RTL and testbench
================================

# seq_scan_ctrl

Controller that sequences a programmable serial pattern matcher over a stream of parallel words. It accepts words through a valid/ready handshake, serialises each word MSB-first into an internal Mealy-style matcher, and counts matches across a multi-word frame. It supports overlapping or non-overlapping detection and reports per-frame results. It sits between a word-wide producer and the status/interrupt logic that consumes hit pulses and counts.

## Interface
- WORD_W, 8, bits per input word, serialised MSB-first.
- PAT_W, 4, pattern length in bits (2..WORD_W).
- CNT_W, 8, width of the per-frame hit counter.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; resets when low at a rising clk edge.
- cfg_we  input  1  configuration write strobe.
- cfg_pattern  input  PAT_W  pattern to detect; bit PAT_W-1 is the first-arriving bit.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  input  1  producer has a word.
- in_data  input  WORD_W  word to scan.
- in_last  input  1  word is the last of its frame; qualified by in_valid.
- in_ready  output  1  controller can accept a word.
- hit  output  1  one-cycle pulse per detected match.
- hit_cnt  output  CNT_W  matches in the current or most recent frame; saturating.
- busy  output  1  a word is being serialised.
- done  output  1  one-cycle pulse after the last bit of an in_last word.

## Operation
- States:
  - IDLE: in_ready=1, busy=0.
  - SHIFT: in_ready=0, busy=1.
- IDLE to SHIFT on in_valid&&in_ready. On that edge:
  - in_data loads into the shift register.
  - in_last is captured.
  - bit index is set to 0.
  - If no frame is open, hit_cnt clears to 0 and the frame opens.
- In SHIFT, one bit (shift register MSB) is evaluated per cycle for WORD_W cycles, then the block returns to IDLE.
- Matcher holds hist (last PAT_W-1 bits) and seen (count of valid history bits, saturating at PAT_W-1).
- Match condition: {hist, bit} == pattern and seen == PAT_W-1.
  - On match with overlap=1: hist and seen update normally.
  - On match with overlap=0: seen clears to 0.
- hist and seen persist across word boundaries within a frame. Matches spanning two words are detected.
- hit_cnt increments by 1 per match and saturates at 2^CNT_W-1.
- Frame end: after the last bit of a word captured with in_last=1:
  - hist and seen clear.
  - The frame closes.
  - done pulses.
  - hit_cnt holds its value until the next frame's first word is accepted.
- Configuration:
  - cfg_we is applied only when state is IDLE and no frame is open. Otherwise it is ignored; there is no queuing.
  - The new pattern takes effect from the next accepted word.
- Reset values: state IDLE, pattern = PAT_W LSBs of 4'b1010 pattern-extended (for PAT_W=4: 1010), overlap=1, hit=0, done=0, hit_cnt=0, busy=0, in_ready=1, frame closed, hist=0, seen=0.

## Timing
- Word accepted at edge E0. Bit k (k=0..WORD_W-1, MSB first) is evaluated in cycle k after E0.
- hit is registered. It is high in the cycle after the evaluation cycle of the completing bit.
- The state returns to IDLE at edge E0+WORD_W. in_ready is high in that cycle. Throughput is one word per WORD_W+1 cycles.
- done is registered. It is high in the same cycle as a hit caused by the final bit, i.e. the first IDLE cycle.
- A new word may be accepted in the same cycle done is high. That word opens a new frame and hit_cnt clears at its acceptance edge.
- in_data and in_last are sampled only at acceptance. Changes while busy have no effect.
- Reset low at any edge, including mid-SHIFT:
  - Next cycle is IDLE with all reset values.
  - The in-flight word is discarded.
  - No hit or done is produced for the discarded word.
  - Configuration returns to defaults.

## Test plan
- Reset: hold rst=0 for 2 cycles -> in_ready=1, busy=0, hit=0, done=0, hit_cnt=0.
- Defaults (1010, overlap), single word 0xAA with in_last=1:
  - 3 hit pulses, in the cycles after bits 3, 5 and 7.
  - done in the 9th cycle after acceptance, alongside the third hit.
  - hit_cnt=3.
- cfg_overlap=0 written in IDLE, then 0xAA with in_last=1 -> 2 hits, hit_cnt=2. Repeat with 0xA5 -> 1 hit.
- Cross-word and frame boundaries:
  - Frame 0x05 (last=0) then 0x00 (last=1) -> exactly 1 hit, after word 2 bit 0, and hit_cnt=1.
  - Next frame 0x00 (last=1) -> hit_cnt clears to 0 at acceptance and there are no hits.
- Config while framed or busy: cfg_we with pattern 0110 during SHIFT and mid-frame -> ignored; 0xAA is still detected as 1010.
- Reset mid-SHIFT after bit 3 of 0xAA -> no further hit, no done, hit_cnt=0, in_ready=1 next cycle. With CNT_W=2, two overlap words 0xAA -> hit_cnt saturates at 3.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Accepts parallel words over a valid/ready handshake, shifts each one
//   MSB-first through a serial pattern matcher and counts matches across a
//   multi-word frame. Matches that straddle word boundaries inside a frame
//   are detected; history is cleared when a frame ends.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-low reset
//   cfg_we       configuration write (honoured only when idle and no frame open)
//   cfg_pattern  pattern to detect, bit PAT_W-1 arrives first
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   in_valid     producer offers a word
//   in_data      word to scan
//   in_last      word closes the current frame
//   in_ready     controller can accept a word (idle)
//   hit          one-cycle pulse per match
//   hit_cnt      saturating match count of the current / most recent frame
//   busy         a word is being serialised
//   done         one-cycle pulse after the last bit of a frame
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int SEEN_W = $clog2(PAT_W);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);
  localparam logic [SEEN_W-1:0] SEEN_FULL = SEEN_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // Reset pattern: alternating 1010... seen from the MSB, truncated to PAT_W.
  function automatic logic [PAT_W-1:0] default_pattern();
    logic [PAT_W-1:0] p;
    for (int i = 0; i < PAT_W; i++) p[i] = (i % 2 == 1);
    return p;
  endfunction

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_word_end;

  logic [WORD_W-1:0]   r_shreg;
  logic                r_last;
  logic [IDX_W-1:0]    r_idx;
  logic [PAT_W-2:0]    r_hist;
  logic [SEEN_W-1:0]   r_seen;
  logic [PAT_W-1:0]    r_pattern;
  logic                r_overlap;
  logic                r_frame_open;
  logic                r_hit;
  logic                r_done;
  logic [CNT_W-1:0]    r_hit_cnt;

  logic                w_bit;
  logic [PAT_W-1:0]    w_window;
  logic                w_match;
  logic [SEEN_W-1:0]   w_seen_nxt;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output is given a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_word_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_idx == LAST_IDX) begin
          w_word_end  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Serial matcher: the bit under evaluation is the shift register MSB.
  // The new history is simply the low PAT_W-1 bits of the current window.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bit      = r_shreg[WORD_W-1];
    w_window   = {r_hist, w_bit};
    w_match    = (r_state == S_SHIFT) && (w_window == r_pattern) &&
                 (r_seen == SEEN_FULL);
    w_seen_nxt = r_seen;
    if (w_match && !r_overlap)  w_seen_nxt = '0;
    else if (r_seen != SEEN_FULL) w_seen_nxt = r_seen + SEEN_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Datapath, configuration and frame bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shreg      <= '0;
      r_last       <= 1'b0;
      r_idx        <= '0;
      r_hist       <= '0;
      r_seen       <= '0;
      r_pattern    <= default_pattern();
      r_overlap    <= 1'b1;
      r_frame_open <= 1'b0;
      r_hit        <= 1'b0;
      r_done       <= 1'b0;
      r_hit_cnt    <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_done <= 1'b0;

      // Reconfiguration is only safe between frames; anything else is dropped.
      if (r_state == S_IDLE && !r_frame_open && cfg_we) begin
        r_pattern <= cfg_pattern;
        r_overlap <= cfg_overlap;
      end

      if (w_accept) begin
        r_shreg <= in_data;
        r_last  <= in_last;
        r_idx   <= '0;
        if (!r_frame_open) begin
          r_hit_cnt    <= '0;
          r_frame_open <= 1'b1;
        end
      end

      if (r_state == S_SHIFT) begin
        r_shreg <= r_shreg << 1;
        r_idx   <= r_idx + IDX_W'(1);
        r_hist  <= w_window[PAT_W-2:0];
        r_seen  <= w_seen_nxt;
        if (w_match) begin
          r_hit <= 1'b1;
          if (r_hit_cnt != CNT_MAX) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
        // Closing a frame overrides the history update above.
        if (w_word_end && r_last) begin
          r_hist       <= '0;
          r_seen       <= '0;
          r_frame_open <= 1'b0;
          r_done       <= 1'b1;
        end
      end
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_SHIFT);
  assign hit      = r_hit;
  assign done     = r_done;
  assign hit_cnt  = r_hit_cnt;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl. A main instance (CNT_W=8) runs the directed
// sequence; a second instance (CNT_W=2) exercises counter saturation.
// Per-cycle hit/done expectations are queued when a word is driven and
// popped as each post-acceptance cycle is sampled on the falling edge.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready, hit, busy, done;
  logic [7:0] hit_cnt;

  logic       s_in_valid;
  logic [7:0] s_in_data;
  logic       s_in_last;
  logic       s_in_ready, s_hit, s_busy, s_done;
  logic [1:0] s_hit_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic hit;
    logic done;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .hit(hit), .hit_cnt(hit_cnt),
    .busy(busy), .done(done)
  );

  seq_scan_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(1'b0), .cfg_pattern(4'b0000),
    .cfg_overlap(1'b0), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_last(s_in_last), .in_ready(s_in_ready), .hit(s_hit),
    .hit_cnt(s_hit_cnt), .busy(s_busy), .done(s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a config write for one cycle; called on a falling edge.
  task automatic cfg_write(input logic [3:0] pat, input logic ov);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_overlap = ov;
    @(negedge clk);
    cfg_we      = 1'b0;
  endtask

  // Offer one word (called on a falling edge), then sample the 9 cycles after
  // acceptance. mask[k] = expected hit from bit k (seen in cycle k+1).
  task automatic run_word(input string name, input logic [7:0] data, input logic last,
                          input logic [7:0] mask, input logic [7:0] cnt0,
                          input logic [7:0] cnt_end, input logic cfg_mid);
    int   waited = 0;
    exp_t e;
    for (int k = 0; k < 8; k++) sb.push_back('{hit: mask[k], done: last && (k == 7)});
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, " accept_in_time"}, 32'(waited < 20), 32'(1));
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after acceptance; they must have no effect.
    in_valid = 1'b0;
    in_data  = ~data;
    in_last  = ~last;
    check({name, " busy_c0"},    32'(busy),     32'(1));
    check({name, " ready_c0"},   32'(in_ready), 32'(0));
    check({name, " hit_cnt_c0"}, 32'(hit_cnt),  32'(cnt0));
    for (int k = 0; k < 8; k++) begin
      if (cfg_mid && k == 1) begin
        cfg_we      = 1'b1;
        cfg_pattern = 4'b0110;
        cfg_overlap = 1'b0;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      if (sb.size() == 0) begin
        check({name, " sb_underflow"}, 32'(0), 32'(1));
      end else begin
        e = sb.pop_front();
        check($sformatf("%s hit_c%0d", name, k + 1),  32'(hit),  32'(e.hit));
        check($sformatf("%s done_c%0d", name, k + 1), 32'(done), 32'(e.done));
      end
    end
    check({name, " ready_end"},   32'(in_ready), 32'(1));
    check({name, " busy_end"},    32'(busy),     32'(0));
    check({name, " hit_cnt_end"}, 32'(hit_cnt),  32'(cnt_end));
  endtask

  // Saturation instance: one word, counting hit and done pulses.
  task automatic run_sat(input logic [7:0] data, input logic last,
                         output int hits, output int dones);
    int waited = 0;
    hits  = 0;
    dones = 0;
    s_in_valid = 1'b1;
    s_in_data  = data;
    s_in_last  = last;
    while (!s_in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("sat accept_in_time", 32'(waited < 20), 32'(1));
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    check("sat busy_c0", 32'(s_busy), 32'(1));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (s_hit)  hits++;
      if (s_done) dones++;
    end
  endtask

  initial begin
    int hits, dones, stray;
    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = 4'b0000; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    s_in_valid = 1'b0; s_in_data = 8'h00; s_in_last = 1'b0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'(1));
    check("rst busy",     32'(busy),     32'(0));
    check("rst hit",      32'(hit),      32'(0));
    check("rst done",     32'(done),     32'(0));
    check("rst hit_cnt",  32'(hit_cnt),  32'(0));
    rst = 1'b1;

    // Defaults 1010 overlapping: hits after bits 3,5,7
    run_word("ov_AA", 8'hAA, 1'b1, 8'hA8, 8'd0, 8'd3, 1'b0);

    // Non-overlapping
    cfg_write(4'b1010, 1'b0);
    run_word("nov_AA", 8'hAA, 1'b1, 8'h88, 8'd0, 8'd2, 1'b0);
    run_word("nov_A5", 8'hA5, 1'b1, 8'h08, 8'd0, 8'd1, 1'b0);

    // Match spanning a word boundary, then a fresh frame clears the count
    run_word("span_w1", 8'h05, 1'b0, 8'h00, 8'd0, 8'd0, 1'b0);
    run_word("span_w2", 8'h00, 1'b1, 8'h01, 8'd0, 8'd1, 1'b0);
    run_word("new_frame", 8'h00, 1'b1, 8'h00, 8'd0, 8'd0, 1'b0);

    // Config writes during SHIFT and between words of an open frame are dropped
    cfg_write(4'b1010, 1'b1);
    run_word("cfg_busy", 8'hAA, 1'b0, 8'hA8, 8'd0, 8'd3, 1'b1);
    cfg_write(4'b0110, 1'b0);
    run_word("cfg_frame", 8'hAA, 1'b1, 8'hAA, 8'd3, 8'd7, 1'b0);

    // New pattern applied between frames
    cfg_write(4'b0110, 1'b0);
    run_word("pat_0110", 8'h66, 1'b1, 8'h88, 8'd0, 8'd2, 1'b0);

    // Reset in the middle of a word
    in_valid = 1'b1; in_data = 8'h66; in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid hit_c3", 32'(hit), 32'(0));
    @(negedge clk);
    check("mid hit_c4",     32'(hit),     32'(1));
    check("mid hit_cnt_c4", 32'(hit_cnt), 32'(1));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid in_ready", 32'(in_ready), 32'(1));
    check("mid busy",     32'(busy),     32'(0));
    check("mid hit",      32'(hit),      32'(0));
    check("mid done",     32'(done),     32'(0));
    check("mid hit_cnt",  32'(hit_cnt),  32'(0));
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (hit || done) stray++;
    end
    check("mid no_stray_pulses", 32'(stray), 32'(0));
    // Configuration back to 1010 overlapping
    run_word("post_rst_AA", 8'hAA, 1'b1, 8'hA8, 8'd0, 8'd3, 1'b0);

    // Saturating 2-bit counter: 3 + 4 matches in one frame
    run_sat(8'hAA, 1'b0, hits, dones);
    check("sat w1 hits",    32'(hits),      32'(3));
    check("sat w1 hit_cnt", 32'(s_hit_cnt), 32'(3));
    run_sat(8'hAA, 1'b1, hits, dones);
    check("sat w2 hits",    32'(hits),      32'(4));
    check("sat w2 done",    32'(dones),     32'(1));
    check("sat w2 hit_cnt", 32'(s_hit_cnt), 32'(3));

    check("sb drained", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
